// File: rtl/subsurf_pkg.sv
// subsurf_pkg -- shared constants and types for the subdivision-surface core.
//
// Contents:
//   RAM_ADDR_W, RAM_WORDS          default OBJ RAM geometry (word address width, capacity)
//   WORDS_PER_VERT, WORDS_PER_FACE stream words per vertex (x,y,z) and per face (3 indices)
//   ST_* constants                 mesh_loader FSM encoding
//   loader_state_t                 enum view of the same encoding, for debug state-string logic
package subsurf_pkg;

    localparam int RAM_ADDR_W     = 9;
    localparam int RAM_WORDS      = 512;
    localparam int WORDS_PER_VERT = 3;
    localparam int WORDS_PER_FACE = 3;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HDR     = 3'd1;
    localparam logic [2:0] ST_VERT    = 3'd2;
    localparam logic [2:0] ST_FACE    = 3'd3;
    localparam logic [2:0] ST_KICK    = 3'd4;
    localparam logic [2:0] ST_WAIT_HI = 3'd5;
    localparam logic [2:0] ST_WAIT_LO = 3'd6;
    localparam logic [2:0] ST_DRAIN   = 3'd7;

    typedef enum logic [2:0] {
        LS_IDLE    = ST_IDLE,
        LS_HDR     = ST_HDR,
        LS_VERT    = ST_VERT,
        LS_FACE    = ST_FACE,
        LS_KICK    = ST_KICK,
        LS_WAIT_HI = ST_WAIT_HI,
        LS_WAIT_LO = ST_WAIT_LO,
        LS_DRAIN   = ST_DRAIN
    } loader_state_t;

endpackage

// File: rtl/mesh_loader_hdr_check.sv
// mesh_hdr_check -- combinational mesh header decode and validation.
//
// Ports:
//   hdr          in   32           header word: [15:0] = V, [31:16] = F
//   v, f         out  16           decoded vertex / face counts
//   vert_end     out  RAM_ADDR_W+1 number of vertex words (3*V), truncated to pointer width
//   total_end    out  RAM_ADDR_W+1 number of payload words (3*(V+F)), truncated to pointer width
//   hdr_ok       out  1            V != 0, F != 0 and 3*(V+F) fits in RAM_WORDS
//
// The word counts are computed at full width (19 bits covers 3*(2*65535)), so
// the capacity compare is exact; the truncated copies are only meaningful when
// hdr_ok is set, which guarantees they fit the pointer.
module mesh_hdr_check
    import subsurf_pkg::*;
#(
    parameter int RAM_ADDR_W = subsurf_pkg::RAM_ADDR_W,
    parameter int RAM_WORDS  = subsurf_pkg::RAM_WORDS
) (
    input  logic [31:0]         hdr,
    output logic [15:0]         v,
    output logic [15:0]         f,
    output logic [RAM_ADDR_W:0] vert_end,
    output logic [RAM_ADDR_W:0] total_end,
    output logic                hdr_ok
);

    logic [18:0] vert_full;
    logic [18:0] face_full;
    logic [18:0] total_full;

    assign v          = hdr[15:0];
    assign f          = hdr[31:16];
    assign vert_full  = {3'b000, v} * 19'(WORDS_PER_VERT);
    assign face_full  = {3'b000, f} * 19'(WORDS_PER_FACE);
    assign total_full = vert_full + face_full;

    assign vert_end   = vert_full[RAM_ADDR_W:0];
    assign total_end  = total_full[RAM_ADDR_W:0];
    assign hdr_ok     = (v != 16'd0) && (f != 16'd0) && (total_full <= 19'(RAM_WORDS));

endmodule

// File: rtl/mesh_loader.sv
// mesh_loader -- streams a mesh (header, vertex words, face words) into the
// OBJ RAM, validates it, then starts subsurf and tracks it to completion.
//
// Optional feature macro: MESH_LOADER_IDX_CHECK_EN
//   defined   -> face words >= V raise err and drain the stream
//   undefined -> face words are written unchecked (no comparator)
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   s_valid/s_ready/s_data/s_last  input word stream
//   RAM_OBJ_EN/WE/A/Di         registered OBJ RAM write port (one cycle after accept)
//   vertex_count, face_count   latched header counts for subsurf
//   subsurf_start              one-cycle start pulse (state KICK)
//   subsurf_busy               busy from subsurf
//   done                       one-cycle pulse when subsurf finishes
//   err                        sticky load error, cleared by the next good header
module mesh_loader
    import subsurf_pkg::*;
#(
    parameter int RAM_ADDR_W = subsurf_pkg::RAM_ADDR_W,
    parameter int RAM_WORDS  = subsurf_pkg::RAM_WORDS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [31:0]           s_data,
    input  logic                  s_last,
    output logic                  RAM_OBJ_EN,
    output logic [3:0]            RAM_OBJ_WE,
    output logic [RAM_ADDR_W-1:0] RAM_OBJ_A,
    output logic [31:0]           RAM_OBJ_Di,
    output logic [31:0]           vertex_count,
    output logic [31:0]           face_count,
    output logic                  subsurf_start,
    input  logic                  subsurf_busy,
    output logic                  done,
    output logic                  err
);

    logic [2:0]            state_reg;
    logic [RAM_ADDR_W:0]   ptr_reg;
    logic [RAM_ADDR_W:0]   vert_end_reg;
    logic [RAM_ADDR_W:0]   total_end_reg;
    logic [31:0]           vertex_count_reg;
    logic [31:0]           face_count_reg;
    logic                  err_reg;
    logic                  done_reg;
    logic                  ram_en_reg;
    logic [RAM_ADDR_W-1:0] ram_addr_reg;
    logic [31:0]           ram_data_reg;

    logic [15:0]           hdr_v;
    logic [15:0]           hdr_f;
    logic [RAM_ADDR_W:0]   hdr_vert_end;
    logic [RAM_ADDR_W:0]   hdr_total_end;
    logic                  hdr_ok;

    logic                  ready_state;
    logic                  accept;
    logic [RAM_ADDR_W:0]   ptr_inc;
    logic                  face_final;
    logic                  idx_bad;

    mesh_hdr_check #(
        .RAM_ADDR_W (RAM_ADDR_W),
        .RAM_WORDS  (RAM_WORDS)
    ) u_hdr_check (
        .hdr       (s_data),
        .v         (hdr_v),
        .f         (hdr_f),
        .vert_end  (hdr_vert_end),
        .total_end (hdr_total_end),
        .hdr_ok    (hdr_ok)
    );

    // Ready depends on state only; held low while reset is asserted.
    always_comb begin
        ready_state = 1'b0;
        case (state_reg)
            ST_IDLE, ST_HDR, ST_VERT, ST_FACE, ST_DRAIN: ready_state = 1'b1;
            default:                                    ready_state = 1'b0;
        endcase
    end

    assign s_ready    = rst_n & ready_state;
    assign accept     = s_valid & s_ready;
    assign ptr_inc    = ptr_reg + {{RAM_ADDR_W{1'b0}}, 1'b1};
    // ptr counts payload words, so the last face word is the one taking ptr to total_end.
    assign face_final = (ptr_inc == total_end_reg);

`ifdef MESH_LOADER_IDX_CHECK_EN
    assign idx_bad = (s_data >= vertex_count_reg);
`else
    assign idx_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            ptr_reg          <= '0;
            vert_end_reg     <= '0;
            total_end_reg    <= '0;
            vertex_count_reg <= '0;
            face_count_reg   <= '0;
            err_reg          <= 1'b0;
            done_reg         <= 1'b0;
            ram_en_reg       <= 1'b0;
            ram_addr_reg     <= '0;
            ram_data_reg     <= '0;
        end else begin
            ram_en_reg <= 1'b0;
            done_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_HDR: begin
                    if (accept) begin
                        // A header that is also the last beat is a framing error.
                        if (!hdr_ok || s_last) begin
                            err_reg   <= 1'b1;
                            state_reg <= s_last ? ST_IDLE : ST_DRAIN;
                        end else begin
                            vertex_count_reg <= {16'd0, hdr_v};
                            face_count_reg   <= {16'd0, hdr_f};
                            vert_end_reg     <= hdr_vert_end;
                            total_end_reg    <= hdr_total_end;
                            ptr_reg          <= '0;
                            err_reg          <= 1'b0;
                            state_reg        <= ST_VERT;
                        end
                    end
                end
                ST_VERT: begin
                    if (accept) begin
                        // F >= 1 is guaranteed, so any s_last here is early.
                        if (s_last) begin
                            err_reg   <= 1'b1;
                            state_reg <= ST_IDLE;
                        end else begin
                            ram_en_reg   <= 1'b1;
                            ram_addr_reg <= ptr_reg[RAM_ADDR_W-1:0];
                            ram_data_reg <= s_data;
                            ptr_reg      <= ptr_inc;
                            if (ptr_inc == vert_end_reg) begin
                                state_reg <= ST_FACE;
                            end
                        end
                    end
                end
                ST_FACE: begin
                    if (accept) begin
                        if (idx_bad || (s_last != face_final)) begin
                            err_reg   <= 1'b1;
                            state_reg <= s_last ? ST_IDLE : ST_DRAIN;
                        end else begin
                            ram_en_reg   <= 1'b1;
                            ram_addr_reg <= ptr_reg[RAM_ADDR_W-1:0];
                            ram_data_reg <= s_data;
                            ptr_reg      <= ptr_inc;
                            if (face_final) begin
                                state_reg <= ST_KICK;
                            end
                        end
                    end
                end
                ST_KICK: begin
                    state_reg <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (subsurf_busy) begin
                        state_reg <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (!subsurf_busy) begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (accept && s_last) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign RAM_OBJ_EN    = ram_en_reg;
    assign RAM_OBJ_WE    = {4{ram_en_reg}};
    assign RAM_OBJ_A     = ram_addr_reg;
    assign RAM_OBJ_Di    = ram_data_reg;
    assign vertex_count  = vertex_count_reg;
    assign face_count    = face_count_reg;
    assign subsurf_start = (state_reg == ST_KICK);
    assign done          = done_reg;
    assign err           = err_reg;

endmodule
